// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the chunked sequential adder.
package adder_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefChunk = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } adder_state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form signed overflow on the final chunk.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // Bit-serial ripple through the chunk.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout     = c[CHUNK];
    c_msb_in = c[CHUNK-1];
  end

endmodule

// File: rtl/adder_seq.sv
// Sequential adder/subtractor: processes CHUNK bits per clock, WIDTH/CHUNK
// cycles per operation, then pulses done for one cycle with the result held.
module adder_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             Carry,
  output logic             Overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  adder_state_t    state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, carry_out_q, overflow_q;
  logic [CntW-1:0]  cnt_q;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_cout, chunk_c_msb_in;

  // Select the operand chunk addressed by the counter.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (cnt_q == CntW'(j)) begin
        chunk_a = a_q[j*CHUNK +: CHUNK];
        chunk_b = b_q[j*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (chunk_a),
    .b        (chunk_b),
    .cin      (carry_q),
    .s        (chunk_s),
    .cout     (chunk_cout),
    .c_msb_in (chunk_c_msb_in)
  );

  // FSM with operand capture, per-chunk accumulation and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            // Subtraction is A + ~B + 1; C0 is ignored in that mode.
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? 1'b1 : C0;
            cnt_q   <= '0;
            state_q <= StBusy;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          for (int unsigned j = 0; j < N; j++) begin
            if (cnt_q == CntW'(j)) sum_q[j*CHUNK +: CHUNK] <= chunk_s;
          end
          carry_q <= chunk_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            // Flags only change on the final chunk so they stay stable otherwise.
            carry_out_q <= chunk_cout;
            overflow_q  <= chunk_cout ^ chunk_c_msb_in;
            state_q     <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StBusy);
  assign done     = (state_q == StDone);
  assign SUM      = sum_q;
  assign Carry    = carry_out_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq (WIDTH=16, CHUNK=4): directed literal cases
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_adder_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk, rst_n, start, C0, sub;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Carry, Overflow;
  logic [WIDTH-1:0] SUM;

  int checks = 0;
  int errors = 0;

  adder_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .C0       (C0),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .SUM      (SUM),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {overflow, carry, sum} from plain integer arithmetic.
  function automatic logic [17:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c0, input logic s);
    logic [15:0] bb;
    logic        ci;
    logic [16:0] full;
    int          r;
    bb   = s ? ~b : b;
    ci   = s ? 1'b1 : c0;
    full = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
    r    = int'($signed(a)) + int'($signed(bb)) + int'(ci);
    return {((r > 32767) || (r < -32768)), full[16], full[15:0]};
  endfunction

  // Transaction-level model: cycles remaining, done flag, held result.
  int unsigned m_rem;
  logic        m_done;
  logic [17:0] m_pend, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_res <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= model_add(A, B, C0, sub);
        m_rem  <= N;
      end
    end
  end

  logic checking = 1'b0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      if (m_rem == 0) begin
        chk("SUM", {16'd0, SUM}, {16'd0, m_res[15:0]});
        chk("Carry", {31'd0, Carry}, {31'd0, m_res[16]});
        chk("Overflow", {31'd0, Overflow}, {31'd0, m_res[17]});
      end
    end
  end

  // One operation with literal expectations; latency counts the start edge as 1.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic s, input logic [15:0] esum,
                        input logic ec, input logic eov);
    int  edges;
    bit  got;
    @(posedge clk); #1;
    start = 1'b1; A = a; B = b; C0 = c0; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    got   = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    if (!got) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_latency"}, edges, N + 1);
      chk({name, "_sum"}, {16'd0, SUM}, {16'd0, esum});
      chk({name, "_carry"}, {31'd0, Carry}, {31'd0, ec});
      chk({name, "_ovf"}, {31'd0, Overflow}, {31'd0, eov});
    end
  endtask

  initial begin
    int pulses;
    logic [15:0] sum_at_done;
    start = 0; A = 0; B = 0; C0 = 0; sub = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 checking = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {16'd0, SUM}, 0);
    chk("rst_carry", {31'd0, Carry}, 0);
    chk("rst_ovf", {31'd0, Overflow}, 0);
    rst_n = 1'b1;

    run_op("add_basic", 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h8001, 1'b0, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin",   16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start re-asserted with different operands two cycles into the operation.
    @(posedge clk); #1;
    start = 1'b1; A = 16'h1000; B = 16'h0234; C0 = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    sum_at_done = '0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        sum_at_done = SUM;
      end
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_sum", {16'd0, sum_at_done}, 32'h1234);

    // Reset two cycles into an operation aborts it and clears outputs at once.
    @(posedge clk); #1;
    start = 1'b1; A = 16'hAAAA; B = 16'h5555; C0 = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_sum", {16'd0, SUM}, 0);
    chk("abort_carry", {31'd0, Carry}, 0);
    chk("abort_ovf", {31'd0, Overflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Randomized traffic, including starts during BUSY and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (c % 700 == 350) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      start = ($urandom % 4 == 0);
      case ($urandom % 6)
        0: A = 16'hFFFF;
        1: A = 16'h8000;
        2: A = 16'h7FFF;
        default: A = 16'($urandom);
      endcase
      case ($urandom % 6)
        0: B = 16'hFFFF;
        1: B = 16'h0001;
        2: B = 16'h0000;
        default: B = 16'($urandom);
      endcase
      C0  = 1'($urandom);
      sub = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
